// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of one SDRAM controller slave, with a read tag FIFO.
// Latency: zero-cycle command path when unlocked; response routing is combinational from the tag FIFO head.
// Backpressure: the granted master sees s_waitrequest and a stalled grant stays locked until it is accepted.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 4
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [ADDR_W-1:0]           m0_address,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DATA_W-1:0]           m0_writedata,
    input  logic [DATA_W/8-1:0]         m0_byteenable,
    output logic                        m0_waitrequest,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,
    input  logic [ADDR_W-1:0]           m1_address,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DATA_W-1:0]           m1_writedata,
    input  logic [DATA_W/8-1:0]         m1_byteenable,
    output logic                        m1_waitrequest,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,
    output logic [ADDR_W-1:0]           s_address,
    output logic                        s_read,
    output logic                        s_write,
    output logic [DATA_W-1:0]           s_writedata,
    output logic [DATA_W/8-1:0]         s_byteenable,
    input  logic                        s_waitrequest,
    input  logic [DATA_W-1:0]           s_readdata,
    input  logic                        s_readdatavalid,
    output logic [$clog2(MAX_PEND):0]   pend_count,
    output logic                        err_unexpected
);
    localparam int PTR_W = $clog2(MAX_PEND);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

    logic             locked_q, locked_d;
    logic             lock_id_q, lock_id_d;
    logic             last_id_q, last_id_d;
    logic             tag_q [MAX_PEND];
    logic             tag_d [MAX_PEND];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic m0_rd, m0_wr, m1_rd, m1_wr, m0_elig, m1_elig;
    logic gnt_vld, gnt_id;
    logic sel_rd, sel_wr, accept, stall, push, pop, head_id;

    // Request decode: read+write together counts as a write; reads need a free tag slot
    always_comb begin
        m0_wr   = m0_write;
        m0_rd   = m0_read & ~m0_write;
        m1_wr   = m1_write;
        m1_rd   = m1_read & ~m1_write;
        m0_elig = m0_wr | (m0_rd & (cnt_q < FULL_CNT));
        m1_elig = m1_wr | (m1_rd & (cnt_q < FULL_CNT));
    end

    // Grant: held on the locked master, otherwise round-robin favouring the master not served last
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!reset_reset_n) begin
            gnt_vld = 1'b0;
        end else if (locked_q) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end else if (m0_elig && m1_elig) begin
            gnt_vld = 1'b1;
            gnt_id  = ~last_id_q;
        end else if (m0_elig) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (m1_elig) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    // Command mux toward the controller, handshake back to the masters, response routing
    always_comb begin
        sel_rd           = gnt_id ? m1_rd : m0_rd;
        sel_wr           = gnt_id ? m1_wr : m0_wr;
        s_read           = gnt_vld & sel_rd;
        s_write          = gnt_vld & sel_wr;
        s_address        = gnt_vld ? (gnt_id ? m1_address : m0_address) : '0;
        s_writedata      = gnt_vld ? (gnt_id ? m1_writedata : m0_writedata) : '0;
        s_byteenable     = gnt_vld ? (gnt_id ? m1_byteenable : m0_byteenable) : '0;
        accept           = gnt_vld & (sel_rd | sel_wr) & ~s_waitrequest;
        stall            = gnt_vld & (sel_rd | sel_wr) & s_waitrequest;
        m0_waitrequest   = (gnt_vld && !gnt_id) ? s_waitrequest : 1'b1;
        m1_waitrequest   = (gnt_vld && gnt_id) ? s_waitrequest : 1'b1;
        push             = accept & sel_rd;
        pop              = s_readdatavalid & (cnt_q != '0);
        head_id          = tag_q[rd_ptr_q];
        m0_readdatavalid = pop & ~head_id;
        m1_readdatavalid = pop & head_id;
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        pend_count       = cnt_q;
        err_unexpected   = err_q;
    end

    // Next state: lock tracking, round-robin history, tag FIFO and sticky error
    always_comb begin
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        last_id_d = last_id_q;
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q | (s_readdatavalid & (cnt_q == '0));
        if (accept) begin
            locked_d  = 1'b0;
            last_id_d = gnt_id;
        end else if (stall) begin
            locked_d  = 1'b1;
            lock_id_d = gnt_id;
        end
        if (push) begin
            tag_d[wr_ptr_q] = gnt_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            locked_q  <= 1'b0;
            lock_id_q <= 1'b0;
            last_id_q <= 1'b1;
            tag_q     <= '{default: 1'b0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            last_id_q <= last_id_d;
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random traffic against a queue-based model.
// Latency: checks each cycle 1-2 time units after the falling edge, model advances per rising edge.
// Backpressure: random slave stalls; bench masters hold commands until the model says accepted.
module tb_sdram_port_arbiter;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int MP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [AW-1:0] m_addr [2];
    logic          m_rd   [2];
    logic          m_wr   [2];
    logic [DW-1:0] m_wdat [2];
    logic [1:0]    m_be   [2];
    logic          m_wait [2];
    logic [DW-1:0] m_rdat [2];
    logic          m_rdv  [2];
    logic [AW-1:0] s_address;
    logic          s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [DW-1:0] s_writedata, s_readdata;
    logic [1:0]    s_byteenable;
    logic [2:0]    pend_count;
    logic          err_unexpected;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
        .m0_writedata(m_wdat[0]), .m0_byteenable(m_be[0]), .m0_waitrequest(m_wait[0]),
        .m0_readdata(m_rdat[0]), .m0_readdatavalid(m_rdv[0]),
        .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
        .m1_writedata(m_wdat[1]), .m1_byteenable(m_be[1]), .m1_waitrequest(m_wait[1]),
        .m1_readdata(m_rdat[1]), .m1_readdatavalid(m_rdv[1]),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .pend_count(pend_count), .err_unexpected(err_unexpected)
    );

    // Reference model state: outstanding read owners in issue order, arbitration history, stalled master
    int            tagq[$];
    logic [DW-1:0] sq[$];
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    int            last_id, lock_id, acc_id;
    bit            err_m;
    bit            busy[2];
    int            n_chk = 0;
    int            n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rdat_of(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    task automatic reset_model();
        tagq.delete(); sq.delete(); mq0.delete(); mq1.delete();
        last_id = 1; lock_id = -1; acc_id = -1; err_m = 0;
        busy[0] = 0; busy[1] = 0;
    endtask

    task automatic set_m(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] be);
        m_rd[i] = rd; m_wr[i] = wr; m_addr[i] = a; m_wdat[i] = d; m_be[i] = be;
    endtask

    task automatic drive_slave(input bit w, input bit v);
        s_waitrequest   = w;
        s_readdatavalid = v;
        s_readdata      = (v && sq.size() > 0) ? sq[0] : 16'($urandom);
    endtask

    // One clock: compare every output with the model, then advance the model as the rising edge would
    task automatic tick();
        bit rd[2], wr[2], el[2], exp_rdv[2];
        int gnt;
        bit cmd, acc;
        #1;
        for (int i = 0; i < 2; i++) begin
            wr[i] = m_wr[i];
            rd[i] = m_rd[i] && !m_wr[i];
            el[i] = wr[i] || (rd[i] && tagq.size() < MP);
        end
        if (lock_id >= 0)         gnt = lock_id;
        else if (el[0] && el[1])  gnt = 1 - last_id;
        else if (el[0])           gnt = 0;
        else if (el[1])           gnt = 1;
        else                      gnt = -1;
        cmd = (gnt >= 0) && (rd[gnt] || wr[gnt]);
        acc = cmd && !s_waitrequest;
        check_eq("s_read", s_read, (gnt >= 0) ? rd[gnt] : 1'b0);
        check_eq("s_write", s_write, (gnt >= 0) ? wr[gnt] : 1'b0);
        check_eq("s_address", s_address, (gnt >= 0) ? m_addr[gnt] : 22'd0);
        check_eq("s_writedata", s_writedata, (gnt >= 0) ? m_wdat[gnt] : 16'd0);
        check_eq("s_byteenable", s_byteenable, (gnt >= 0) ? m_be[gnt] : 2'd0);
        check_eq("m0_wait", m_wait[0], (gnt == 0) ? s_waitrequest : 1'b1);
        check_eq("m1_wait", m_wait[1], (gnt == 1) ? s_waitrequest : 1'b1);
        exp_rdv[0] = 0; exp_rdv[1] = 0;
        if (s_readdatavalid && tagq.size() > 0) exp_rdv[tagq[0]] = 1;
        check_eq("m0_rdv", m_rdv[0], exp_rdv[0]);
        check_eq("m1_rdv", m_rdv[1], exp_rdv[1]);
        check_eq("pend_count", pend_count, tagq.size());
        check_eq("err_unexpected", err_unexpected, err_m);
        if (exp_rdv[0] && mq0.size() > 0) check_eq("m0_rdata", m_rdat[0], mq0.pop_front());
        if (exp_rdv[1] && mq1.size() > 0) check_eq("m1_rdata", m_rdat[1], mq1.pop_front());
        if (s_readdatavalid) begin
            if (sq.size() > 0) void'(sq.pop_front());
            if (tagq.size() > 0) void'(tagq.pop_front());
            else err_m = 1;
        end
        acc_id = -1;
        if (acc) begin
            acc_id  = gnt;
            last_id = gnt;
            lock_id = -1;
            if (rd[gnt]) begin
                tagq.push_back(gnt);
                sq.push_back(rdat_of(m_addr[gnt]));
                if (gnt == 0) mq0.push_back(rdat_of(m_addr[gnt]));
                else          mq1.push_back(rdat_of(m_addr[gnt]));
            end
        end else if (cmd) begin
            lock_id = gnt;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && tagq.size() > 0; c++) begin
            drive_slave(0, 1);
            tick();
        end
        check_eq("drained", tagq.size(), 0);
        drive_slave(0, 0);
    endtask

    initial begin
        reset_model();
        rst_n = 1'b0;
        set_m(0, 1, 0, 22'h1, 16'h0, 2'b11);
        set_m(1, 0, 0, 22'h0, 16'h0, 2'b00);
        drive_slave(0, 0);
        #12;
        check_eq("rst_pend", pend_count, 0);
        check_eq("rst_err", err_unexpected, 0);
        check_eq("rst_s_read", s_read, 0);
        check_eq("rst_m0_wait", m_wait[0], 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone m0 write goes straight through
        set_m(0, 0, 1, 22'h00010, 16'hBEEF, 2'b11);
        #1;
        check_eq("t1_s_write", s_write, 1);
        check_eq("t1_addr", s_address, 22'h00010);
        check_eq("t1_data", s_writedata, 16'hBEEF);
        check_eq("t1_m0_wait", m_wait[0], 0);
        check_eq("t1_m1_wait", m_wait[1], 1);
        tick();
        check_eq("t1_pend", pend_count, 0);

        // m1 stalled four cycles while m0 waits, then m0 next
        set_m(0, 1, 0, 22'h0A0A0, 16'h0, 2'b11);
        set_m(1, 1, 0, 22'h1B1B1, 16'h0, 2'b11);
        for (int c = 0; c < 4; c++) begin
            drive_slave(1, 0);
            #1;
            check_eq("lock_addr", s_address, 22'h1B1B1);
            check_eq("lock_m0_wait", m_wait[0], 1);
            tick();
        end
        drive_slave(0, 0);
        #1;
        check_eq("lock_m1_acc", m_wait[1], 0);
        tick();
        set_m(1, 0, 0, 22'h0, 16'h0, 2'b00);
        #1;
        check_eq("lock_m0_next", m_wait[0], 0);
        check_eq("lock_m0_addr", s_address, 22'h0A0A0);
        tick();
        set_m(0, 0, 0, 22'h0, 16'h0, 2'b00);
        drain();

        // Tag FIFO full: 5th read blocked while m1 write proceeds; a pop frees it one cycle later
        for (int k = 0; k < 4; k++) begin
            set_m(0, 1, 0, 22'(k + 8), 16'h0, 2'b11);
            #1;
            check_eq("full_acc", m_wait[0], 0);
            tick();
        end
        set_m(0, 1, 0, 22'h00100, 16'h0, 2'b11);
        set_m(1, 0, 1, 22'h00200, 16'h1234, 2'b01);
        #1;
        check_eq("full_m0_blk", m_wait[0], 1);
        check_eq("full_m1_wr", m_wait[1], 0);
        tick();
        set_m(1, 0, 0, 22'h0, 16'h0, 2'b00);
        drive_slave(0, 1);
        #1;
        check_eq("full_samecyc", m_wait[0], 1);
        tick();
        drive_slave(0, 0);
        #1;
        check_eq("full_freed", m_wait[0], 0);
        tick();
        set_m(0, 0, 0, 22'h0, 16'h0, 2'b00);
        drain();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!busy[i]) begin
                    int r;
                    r = $urandom % 10;
                    set_m(i, (r >= 4 && r <= 6) || r == 9, r >= 7, 22'($urandom), 16'($urandom),
                          2'($urandom));
                    busy[i] = (r >= 4);
                end
            end
            drive_slave($urandom % 4 == 0, sq.size() > 0 && $urandom % 3 == 0);
            tick();
            if (acc_id >= 0) busy[acc_id] = 0;
        end
        for (int c = 0; c < 40 && (busy[0] || busy[1]); c++) begin
            for (int i = 0; i < 2; i++) if (!busy[i]) set_m(i, 0, 0, 22'h0, 16'h0, 2'b00);
            drive_slave(0, sq.size() > 0);
            tick();
            if (acc_id >= 0) busy[acc_id] = 0;
        end
        check_eq("wind_down", busy[0] || busy[1], 0);
        set_m(0, 0, 0, 22'h0, 16'h0, 2'b00);
        set_m(1, 0, 0, 22'h0, 16'h0, 2'b00);
        drain();

        // Spurious response with nothing outstanding
        drive_slave(0, 1);
        tick();
        drive_slave(0, 0);
        tick();
        check_eq("err_sticky", err_unexpected, 1);

        // Reset with two reads outstanding and m0 locked
        set_m(0, 1, 0, 22'h00033, 16'h0, 2'b11);
        tick();
        tick();
        drive_slave(1, 0);
        tick();
        set_m(1, 1, 0, 22'h00044, 16'h0, 2'b11);
        drive_slave(1, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst2_pend", pend_count, 0);
        check_eq("rst2_err", err_unexpected, 0);
        check_eq("rst2_s_read", s_read, 0);
        check_eq("rst2_m0_wait", m_wait[0], 1);
        check_eq("rst2_m1_wait", m_wait[1], 1);
        check_eq("rst2_rdv", m_rdv[0] | m_rdv[1], 0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        drive_slave(0, 0);
        set_m(0, 0, 1, 22'h00055, 16'h5555, 2'b11);
        set_m(1, 0, 1, 22'h00066, 16'h6666, 2'b11);
        #1;
        check_eq("rst2_m0_first", m_wait[0], 0);
        check_eq("rst2_m1_held", m_wait[1], 1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
